// File: rtl/banked_sram.sv
// banked_sram: multi-bank, multi-read-port scratchpad for attention K/V/Q tiles.
// Words are interleaved across NUM_BANKS 1R1W banks on the low address bits.
// Each bank arbitrates its read ports independently.
// Read responses come back a fixed READ_LATENCY (1 or 2) cycles after accept.
// Writes are byte-masked.
// A zero-fill sweep runs after reset and whenever clear is pulsed.
// Optional build macro: SRAM_WRITE_BYPASS_EN. When it is defined, a read
// accepted in the same cycle as a write to the same address returns the
// merged (newly written) word instead of the old one.
module banked_sram #(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 256,
  parameter int NUM_BANKS    = 4,
  parameter int READ_PORTS   = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       clear,
  output logic                                       init_done,
  input  logic [READ_PORTS-1:0]                      rd_req_valid,
  output logic [READ_PORTS-1:0]                      rd_req_ready,
  input  logic [READ_PORTS-1:0][$clog2(DEPTH)-1:0]   rd_req_addr,
  output logic [READ_PORTS-1:0]                      rd_rsp_valid,
  output logic [READ_PORTS-1:0][WIDTH-1:0]           rd_rsp_data,
  input  logic                                       wr_valid,
  output logic                                       wr_ready,
  input  logic [$clog2(DEPTH)-1:0]                   wr_addr,
  input  logic [WIDTH/8-1:0]                         wr_be,
  input  logic [WIDTH-1:0]                           wr_data
);

  localparam int AW     = $clog2(DEPTH);
  localparam int BB     = $clog2(NUM_BANKS);
  localparam int ROWS   = DEPTH / NUM_BANKS;
  localparam int RW     = AW - BB;
  localparam int NBYTES = WIDTH / 8;

  typedef enum logic {INIT, RUN} state_e;

  state_e          state_q;
  logic [RW-1:0]   sweepRow_q;
  logic            initDone_q;
  logic            run;

  logic            wrFire;
  logic [BB-1:0]   wrBank;
  logic [RW-1:0]   wrRow;

  logic [READ_PORTS-1:0][BB-1:0] rdBank;
  logic [READ_PORTS-1:0][RW-1:0] rdRow;

  logic            arbDecided;
  logic            arbGrant;

  logic [NUM_BANKS-1:0][READ_PORTS-1:0][WIDTH-1:0] bankRd;
  logic [READ_PORTS-1:0][WIDTH-1:0]                rspData_d;
  logic [READ_PORTS-1:0]                           rspValid1_q;
  logic [READ_PORTS-1:0][WIDTH-1:0]                rspData1_q;

  assign run       = (state_q == RUN);
  assign init_done = initDone_q;
  assign wr_ready  = run;
  assign wrFire    = wr_valid && run;
  assign wrBank    = wr_addr[BB-1:0];
  assign wrRow     = wr_addr[AW-1:BB];

  // Sweep/run controller. The sweep zeroes one row of every bank per cycle.
  // clear restarts the sweep from row 0 regardless of the current state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT;
      sweepRow_q <= '0;
      initDone_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (clear) begin
            sweepRow_q <= '0;
          end else if (sweepRow_q == RW'(ROWS - 1)) begin
            state_q    <= RUN;
            sweepRow_q <= '0;
            initDone_q <= 1'b1;
          end else begin
            sweepRow_q <= sweepRow_q + 1'b1;
          end
        end
        RUN: begin
          if (clear) begin
            state_q    <= INIT;
            sweepRow_q <= '0;
            initDone_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= INIT;
          sweepRow_q <= '0;
          initDone_q <= 1'b0;
        end
      endcase
    end
  end

  // Split each read address into its bank select (low bits) and row.
  always_comb begin
    rdBank = '0;
    rdRow  = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      rdBank[p] = rd_req_addr[p][BB-1:0];
      rdRow[p]  = rd_req_addr[p][AW-1:BB];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
    logic [WIDTH-1:0] mem_q [ROWS];

    // Bank storage: the zero sweep owns the write port outside RUN.
    // In RUN, accepted writes to this bank update only the enabled bytes.
    always_ff @(posedge clock) begin
      if (!run) begin
        mem_q[sweepRow_q] <= '0;
      end else if (wrFire && (wrBank == BB'(b))) begin
        for (int by = 0; by < NBYTES; by++) begin
          if (wr_be[by]) begin
            mem_q[wrRow][by*8 +: 8] <= wr_data[by*8 +: 8];
          end
        end
      end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : gPort
      assign bankRd[b][p] = mem_q[rdRow[p]];
    end
  end

  // Per-bank arbitration. The first valid port aimed at a bank sets that
  // bank's address. Later ports are granted only if they hit the same word.
  always_comb begin
    rd_req_ready = '0;
    arbDecided   = 1'b0;
    arbGrant     = 1'b0;
    for (int i = 0; i < READ_PORTS; i++) begin
      arbDecided = 1'b0;
      arbGrant   = 1'b1;
      for (int j = 0; j < i; j++) begin
        if (!arbDecided && rd_req_valid[j] && (rdBank[j] == rdBank[i])) begin
          arbDecided = 1'b1;
          arbGrant   = (rd_req_addr[j] == rd_req_addr[i]);
        end
      end
      rd_req_ready[i] = run && rd_req_valid[i] && arbGrant;
    end
  end

  // Select the word for each accepted read, merging a same-cycle write when
  // bypass is built in. Ports that are not accepted carry zero.
  always_comb begin
    rspData_d = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      rspData_d[p] = bankRd[rdBank[p]][p];
`ifdef SRAM_WRITE_BYPASS_EN
      if (wrFire && (wr_addr == rd_req_addr[p])) begin
        for (int by = 0; by < NBYTES; by++) begin
          if (wr_be[by]) begin
            rspData_d[p][by*8 +: 8] = wr_data[by*8 +: 8];
          end
        end
      end
`endif
      if (!rd_req_ready[p]) begin
        rspData_d[p] = '0;
      end
    end
  end

  // First response stage. Reset drops anything in flight; clear does not.
  always_ff @(posedge clock) begin
    if (reset) begin
      rspValid1_q <= '0;
      rspData1_q  <= '0;
    end else begin
      rspValid1_q <= rd_req_ready;
      rspData1_q  <= rspData_d;
    end
  end

  if (READ_LATENCY == 2) begin : gLat2
    logic [READ_PORTS-1:0]            rspValid2_q;
    logic [READ_PORTS-1:0][WIDTH-1:0] rspData2_q;

    // Optional second response stage for the two-cycle latency build.
    always_ff @(posedge clock) begin
      if (reset) begin
        rspValid2_q <= '0;
        rspData2_q  <= '0;
      end else begin
        rspValid2_q <= rspValid1_q;
        rspData2_q  <= rspData1_q;
      end
    end

    assign rd_rsp_valid = rspValid2_q;
    assign rd_rsp_data  = rspData2_q;
  end else begin : gLat1
    assign rd_rsp_valid = rspValid1_q;
    assign rd_rsp_data  = rspData1_q;
  end

endmodule

// File: tb/tb_banked_sram.sv
// tb_banked_sram: bench for banked_sram.
// A flat word-array model predicts ready, response and init outputs every
// cycle. Directed literal checks pin the model.
// Honours SRAM_WRITE_BYPASS_EN in the same way as the design.
module tb_banked_sram;

  localparam int WIDTH = 64;
  localparam int DEPTH = 256;
  localparam int NB    = 4;
  localparam int RP    = 2;
  localparam int LAT   = 1;
  localparam int AW    = 8;
  localparam int ROWS  = DEPTH / NB;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      clear;
  logic                      init_done;
  logic [RP-1:0]             rd_req_valid;
  logic [RP-1:0]             rd_req_ready;
  logic [RP-1:0][AW-1:0]     rd_req_addr;
  logic [RP-1:0]             rd_rsp_valid;
  logic [RP-1:0][WIDTH-1:0]  rd_rsp_data;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [AW-1:0]             wr_addr;
  logic [WIDTH/8-1:0]        wr_be;
  logic [WIDTH-1:0]          wr_data;

  int checks = 0;
  int errors = 0;

  banked_sram #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_BANKS(NB),
    .READ_PORTS(RP), .READ_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear), .init_done(init_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_data(rd_rsp_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural reference: flat memory, sweep position, and per-port
  // expected responses indexed by the cycle they are due.
  logic [63:0] modelMem [DEPTH];
  bit          modelRun;
  int          sweepRow;
  bit          expV [RP][4];
  logic [63:0] expD [RP][4];
  int          cyc;

  initial begin
    bit          has [NB];
    logic [7:0]  win [NB];
    logic [1:0]  expReady;
    logic [63:0] word;
    int          bk;
    int          slot;
    modelRun = 1'b0;
    sweepRow = 0;
    cyc      = 0;
    for (int a = 0; a < DEPTH; a++) modelMem[a] = '0;
    for (int p = 0; p < RP; p++)
      for (int s = 0; s < 4; s++) begin
        expV[p][s] = 1'b0;
        expD[p][s] = '0;
      end
    forever begin
      @(negedge clock);
      slot = cyc % 4;
      for (int p = 0; p < RP; p++) begin
        checkOutput("rsp_valid", {63'd0, rd_rsp_valid[p]}, {63'd0, expV[p][slot]});
        checkOutput("rsp_data", rd_rsp_data[p], expD[p][slot]);
        expV[p][slot] = 1'b0;
        expD[p][slot] = '0;
      end
      checkOutput("init_done", {63'd0, init_done}, {63'd0, modelRun});
      checkOutput("wr_ready", {63'd0, wr_ready}, {63'd0, modelRun});

      for (int b = 0; b < NB; b++) begin
        has[b] = 1'b0;
        win[b] = '0;
      end
      for (int p = 0; p < RP; p++) begin
        bk = int'(rd_req_addr[p]) % NB;
        if (rd_req_valid[p] && !has[bk]) begin
          has[bk] = 1'b1;
          win[bk] = rd_req_addr[p];
        end
      end
      expReady = '0;
      for (int p = 0; p < RP; p++) begin
        bk = int'(rd_req_addr[p]) % NB;
        expReady[p] = modelRun && rd_req_valid[p] && (win[bk] == rd_req_addr[p]);
      end
      checkOutput("rd_req_ready", {62'd0, rd_req_ready}, {62'd0, expReady});

      for (int p = 0; p < RP; p++) begin
        if (expReady[p]) begin
          word = modelMem[rd_req_addr[p]];
`ifdef SRAM_WRITE_BYPASS_EN
          if (wr_valid && (wr_addr == rd_req_addr[p]))
            for (int by = 0; by < 8; by++)
              if (wr_be[by]) word[by*8 +: 8] = wr_data[by*8 +: 8];
`endif
          expV[p][(cyc + LAT) % 4] = 1'b1;
          expD[p][(cyc + LAT) % 4] = word;
        end
      end

      if (reset) begin
        for (int p = 0; p < RP; p++)
          for (int s = 0; s < 4; s++) begin
            expV[p][s] = 1'b0;
            expD[p][s] = '0;
          end
        modelRun = 1'b0;
        sweepRow = 0;
      end else if (!modelRun) begin
        for (int b = 0; b < NB; b++) modelMem[sweepRow * NB + b] = '0;
        if (clear) sweepRow = 0;
        else if (sweepRow == ROWS - 1) begin
          modelRun = 1'b1;
          sweepRow = 0;
        end else sweepRow++;
      end else begin
        if (wr_valid)
          for (int by = 0; by < 8; by++)
            if (wr_be[by]) modelMem[wr_addr][by*8 +: 8] = wr_data[by*8 +: 8];
        if (clear) begin
          modelRun = 1'b0;
          sweepRow = 0;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [7:0] a0,
                               input logic [7:0] a1, input logic wv,
                               input logic [7:0] wa, input logic [7:0] be,
                               input logic [63:0] wd, input logic clr);
    rd_req_valid   = v;
    rd_req_addr[0] = a0;
    rd_req_addr[1] = a1;
    wr_valid       = wv;
    wr_addr        = wa;
    wr_be          = be;
    wr_data        = wd;
    clear          = clr;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 64'd0, 1'b0);
  endtask

  task automatic waitRsp();
    repeat (LAT - 1) tick();
    #1;
  endtask

  task automatic waitInit();
    int n = 0;
    while (!init_done && n < 200) begin
      tick();
      n++;
    end
    checkOutput("init_wait_bound", {63'd0, (n < 200)}, 64'd1);
  endtask

  initial begin
    logic [1:0] v;
    logic [7:0] a [RP];
    logic [1:0] acc;
    reset = 1'b1;
    idle();
    repeat (3) tick();
    reset = 1'b0;

    // Sweep takes exactly ROWS cycles after reset release.
    for (int k = 1; k <= 65; k++) begin
      #1;
      if (k == 1 || k == 64 || k == 65)
        checkOutput("init_done_timing", {63'd0, init_done}, {63'd0, (k == 65)});
      tick();
    end

    // Reads before any write return zero.
    applyStimulus(2'b11, 8'd0, 8'd9, 1'b0, 8'd0, 8'd0, 64'd0, 1'b0);
    #1 checkOutput("ready_diff_banks", {62'd0, rd_req_ready}, 64'd3);
    tick(); idle(); waitRsp();
    checkOutput("zero_rd0", rd_rsp_data[0], 64'd0);
    checkOutput("zero_rd1", rd_rsp_data[1], 64'd0);
    tick();

    // Byte-masked merge.
    applyStimulus(2'b00, 8'd0, 8'd0, 1'b1, 8'd5, 8'hFF, 64'h1122334455667788, 1'b0);
    tick();
    applyStimulus(2'b00, 8'd0, 8'd0, 1'b1, 8'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0);
    tick();
    applyStimulus(2'b01, 8'd5, 8'd0, 1'b0, 8'd0, 8'd0, 64'd0, 1'b0);
    tick(); idle(); waitRsp();
    checkOutput("byte_merge", rd_rsp_data[0], 64'h11223344AAAAAAAA);
    tick();

    // Bank conflict: port0 wins, port1 holds and goes next cycle.
    applyStimulus(2'b11, 8'd4, 8'd8, 1'b0, 8'd0, 8'd0, 64'd0, 1'b0);
    #1 checkOutput("conflict_ready", {62'd0, rd_req_ready}, 64'd1);
    tick();
    applyStimulus(2'b10, 8'd4, 8'd8, 1'b0, 8'd0, 8'd0, 64'd0, 1'b0);
    #1 checkOutput("conflict_retry", {62'd0, rd_req_ready}, 64'd2);
    tick(); idle();
    repeat (3) tick();

    // Broadcast of identical address.
    applyStimulus(2'b00, 8'd0, 8'd0, 1'b1, 8'd12, 8'hFF, 64'h0000000000C0FFEE, 1'b0);
    tick();
    applyStimulus(2'b11, 8'd12, 8'd12, 1'b0, 8'd0, 8'd0, 64'd0, 1'b0);
    #1 checkOutput("broadcast_ready", {62'd0, rd_req_ready}, 64'd3);
    tick(); idle(); waitRsp();
    checkOutput("broadcast_d0", rd_rsp_data[0], 64'h0000000000C0FFEE);
    checkOutput("broadcast_d1", rd_rsp_data[1], 64'h0000000000C0FFEE);
    tick();
    applyStimulus(2'b11, 8'd1, 8'd2, 1'b0, 8'd0, 8'd0, 64'd0, 1'b0);
    #1 checkOutput("two_banks_ready", {62'd0, rd_req_ready}, 64'd3);
    tick(); idle(); tick();

    // Same-cycle write and read.
    applyStimulus(2'b00, 8'd0, 8'd0, 1'b1, 8'd7, 8'hFF, 64'h1111111111111111, 1'b0);
    tick();
    applyStimulus(2'b01, 8'd7, 8'd0, 1'b1, 8'd7, 8'hFF, 64'h0123456789ABCDEF, 1'b0);
    tick(); idle(); waitRsp();
`ifdef SRAM_WRITE_BYPASS_EN
    checkOutput("same_cycle_rw", rd_rsp_data[0], 64'h0123456789ABCDEF);
`else
    checkOutput("same_cycle_rw", rd_rsp_data[0], 64'h1111111111111111);
`endif
    tick();
    applyStimulus(2'b01, 8'd7, 8'd0, 1'b0, 8'd0, 8'd0, 64'd0, 1'b0);
    tick(); idle(); waitRsp();
    checkOutput("after_write_rd", rd_rsp_data[0], 64'h0123456789ABCDEF);
    tick();

    // Clear with a read in flight, then hold a read across the sweep.
    applyStimulus(2'b00, 8'd0, 8'd0, 1'b1, 8'd3, 8'hFF, 64'h000000000000DEAD, 1'b0);
    tick();
    applyStimulus(2'b01, 8'd3, 8'd0, 1'b0, 8'd0, 8'd0, 64'd0, 1'b1);
    #1 checkOutput("clear_cycle_ready", {62'd0, rd_req_ready}, 64'd1);
    tick();
    applyStimulus(2'b01, 8'd3, 8'd0, 1'b0, 8'd0, 8'd0, 64'd0, 1'b0);
    for (int k = 1; k <= 65; k++) begin
      #1;
      if (k == LAT) checkOutput("inflight_predata", rd_rsp_data[0], 64'h000000000000DEAD);
      if (k == 1 || k == 64) checkOutput("sweep_ready_low", {62'd0, rd_req_ready}, 64'd0);
      if (k == 65) checkOutput("sweep_done_ready", {62'd0, rd_req_ready}, 64'd1);
      tick();
    end
    idle(); waitRsp();
    checkOutput("post_sweep_valid", {63'd0, rd_rsp_valid[0]}, 64'd1);
    checkOutput("post_sweep_data", rd_rsp_data[0], 64'd0);
    tick();

    // Reset with a response pending drops it.
    applyStimulus(2'b01, 8'd5, 8'd0, 1'b0, 8'd0, 8'd0, 64'd0, 1'b0);
    reset = 1'b1;
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      #1 checkOutput("reset_drop", {62'd0, rd_rsp_valid}, 64'd0);
      tick();
    end
    reset = 1'b0;
    waitInit();

    // Randomised traffic; blocked ports hold their request.
    v   = '0;
    acc = '0;
    for (int p = 0; p < RP; p++) a[p] = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < RP; p++) begin
        if (!v[p] || acc[p]) begin
          v[p] = ($urandom_range(0, 99) < 60);
          a[p] = 8'($urandom_range(0, 15));
        end
      end
      applyStimulus(v, a[0], a[1], ($urandom_range(0, 99) < 40),
                    8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                    {$urandom, $urandom}, ($urandom_range(0, 499) == 0));
      #1 acc = rd_req_valid & rd_req_ready;
      tick();
    end
    idle();
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
